// File: rtl/sent_pkg.sv
// Shared SENT constants, interval-classification limits and receiver state/error encodings.
// Used by both the transmit pulse generator and the receive pulse decoder.
package sent_pkg;

    localparam logic [9:0] SYNC_TICKS    = 10'd56;
    localparam logic [9:0] NIB_OFFSET    = 10'd12;
    localparam logic [9:0] NIB_MAX_TICKS = 10'd27;
    localparam logic [9:0] PAUSE_MIN     = 10'd12;
    localparam logic [9:0] PAUSE_MAX     = 10'd768;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        DATA,
        PAUSE
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_NIBBLE    = 2'b01;
    localparam logic [1:0] ERR_LOW_TIME  = 2'b10;
    localparam logic [1:0] ERR_FRAME_LEN = 2'b11;

endpackage

// File: rtl/sent_rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by registered rise/fall detection.
// RESET_VAL is the idle level the input is assumed to hold while in reset.
module sent_rx_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_tx,
    input  logic reset_n_tx,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            meta   <= RESET_VAL;
            sync   <= RESET_VAL;
            sync_d <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
            fall   <= ~sync & sync_d;
        end
    end

    assign level = sync;

endmodule

// File: rtl/sent_rx_pulse_decoder.sv
// SENT receive pulse decoder: measures falling-edge intervals in ticks and decodes sync/nibble/pause.
// Optional total-frame-length check is enabled by defining SENT_RX_FRAME_CHECK_EN.
module sent_rx_pulse_decoder
    import sent_pkg::*;
#(
    parameter int NIBBLES     = 6,
    parameter int LOW_MIN     = 4,
    parameter int IDLE_TICKS  = 64,
    parameter int FRAME_TICKS = 280
) (
    input  logic       clk_tx,
    input  logic       reset_n_tx,
    input  logic       ticks_i,
    input  logic       sent_rx_i,
    output logic [3:0] nibble_o,
    output logic [3:0] nibble_idx_o,
    output logic       nibble_valid_o,
    output logic       sync_o,
    output logic       pause_o,
    output logic       frame_done_o,
    output logic       idle_o,
    output logic       err_o,
    output logic [1:0] err_code_o
);

    localparam int LOW_W  = $clog2(LOW_MIN + 1);
    localparam int HIGH_W = $clog2(IDLE_TICKS + 1);
    localparam logic [3:0] LAST_IDX = 4'(NIBBLES + 1);

    logic line_level, line_rise, line_fall;
    logic tick, tick_level, tick_fall;
    logic unused_tick_edges;

    sent_rx_sync_edge #(.RESET_VAL(1'b1)) u_line_edge (
        .clk_tx     (clk_tx),
        .reset_n_tx (reset_n_tx),
        .async_in   (sent_rx_i),
        .level      (line_level),
        .rise       (line_rise),
        .fall       (line_fall)
    );

    sent_rx_sync_edge #(.RESET_VAL(1'b0)) u_tick_edge (
        .clk_tx     (clk_tx),
        .reset_n_tx (reset_n_tx),
        .async_in   (ticks_i),
        .level      (tick_level),
        .rise       (tick),
        .fall       (tick_fall)
    );

    assign unused_tick_edges = tick_level ^ tick_fall;

    logic [9:0]        interval_cnt;
    logic [LOW_W-1:0]  low_cnt;
    logic [HIGH_W-1:0] high_cnt;

    // A falling edge closes the interval; a coincident tick starts the new one at zero.
    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            interval_cnt <= '0;
            low_cnt      <= '0;
            high_cnt     <= '0;
        end else begin
            if (line_fall)
                interval_cnt <= '0;
            else if (tick && interval_cnt != 10'h3FF)
                interval_cnt <= interval_cnt + 10'd1;

            if (line_fall)
                low_cnt <= '0;
            else if (tick && !line_level && low_cnt < LOW_W'(LOW_MIN))
                low_cnt <= low_cnt + 1'b1;

            if (!line_level)
                high_cnt <= '0;
            else if (tick && high_cnt < HIGH_W'(IDLE_TICKS))
                high_cnt <= high_cnt + 1'b1;
        end
    end

    state_t     state;
    logic       armed;
    logic [3:0] idx;

    logic       classify, is_sync, is_nib, is_pause, idle_hit, frame_len_bad;
    logic [3:0] nib_val;

    assign classify = line_fall && armed;
    assign is_sync  = interval_cnt == SYNC_TICKS;
    assign is_nib   = interval_cnt >= NIB_OFFSET && interval_cnt <= NIB_MAX_TICKS;
    assign is_pause = interval_cnt >= PAUSE_MIN && interval_cnt <= PAUSE_MAX;
    assign nib_val  = 4'(interval_cnt - NIB_OFFSET);
    assign idle_hit = tick && line_level && high_cnt == HIGH_W'(IDLE_TICKS - 1);

`ifdef SENT_RX_FRAME_CHECK_EN
    logic [9:0]  frame_acc;
    logic [10:0] acc_sum;
    logic [9:0]  acc_next;

    assign acc_sum       = {1'b0, frame_acc} + {1'b0, interval_cnt};
    assign acc_next      = acc_sum[10] ? 10'h3FF : acc_sum[9:0];
    assign frame_len_bad = acc_next != 10'(FRAME_TICKS);

    // The sync interval itself is the first term of the frame sum.
    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx)
            frame_acc <= '0;
        else if (idle_hit)
            frame_acc <= '0;
        else if (classify && is_sync)
            frame_acc <= interval_cnt;
        else if (classify && state == DATA && is_nib)
            frame_acc <= acc_next;
    end
`else
    logic [9:0] unused_frame_ticks;
    assign unused_frame_ticks = 10'(FRAME_TICKS);
    assign frame_len_bad      = 1'b0;
`endif

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state          <= WAIT_SYNC;
            armed          <= 1'b0;
            idx            <= '0;
            nibble_o       <= '0;
            nibble_idx_o   <= '0;
            nibble_valid_o <= 1'b0;
            sync_o         <= 1'b0;
            pause_o        <= 1'b0;
            frame_done_o   <= 1'b0;
            idle_o         <= 1'b1;
            err_o          <= 1'b0;
            err_code_o     <= ERR_NONE;
        end else begin
            nibble_valid_o <= 1'b0;
            sync_o         <= 1'b0;
            pause_o        <= 1'b0;
            frame_done_o   <= 1'b0;
            err_o          <= 1'b0;

            if (line_fall) begin
                idle_o <= 1'b0;
                armed  <= 1'b1;
            end

            if (classify) begin
                case (state)
                    WAIT_SYNC: begin
                        if (is_sync) begin
                            sync_o <= 1'b1;
                            idx    <= '0;
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        if (is_nib) begin
                            nibble_valid_o <= 1'b1;
                            nibble_o       <= nib_val;
                            nibble_idx_o   <= idx;
                            idx            <= idx + 4'd1;
                            if (idx == LAST_IDX) begin
                                frame_done_o <= 1'b1;
                                state        <= PAUSE;
                            end
                        end else if (is_sync) begin
                            // Short frame: report it, but resynchronise on this sync.
                            err_o      <= 1'b1;
                            err_code_o <= ERR_NIBBLE;
                            sync_o     <= 1'b1;
                            idx        <= '0;
                        end else begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_NIBBLE;
                            state      <= WAIT_SYNC;
                        end
                    end
                    PAUSE: begin
                        if (is_sync) begin
                            sync_o <= 1'b1;
                            idx    <= '0;
                            state  <= DATA;
                        end else if (is_pause) begin
                            pause_o <= 1'b1;
                            state   <= WAIT_SYNC;
                            if (frame_len_bad) begin
                                err_o      <= 1'b1;
                                err_code_o <= ERR_FRAME_LEN;
                            end
                        end else begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_NIBBLE;
                            state      <= WAIT_SYNC;
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end

            if (line_rise && armed && low_cnt < LOW_W'(LOW_MIN)) begin
                err_o      <= 1'b1;
                err_code_o <= ERR_LOW_TIME;
                state      <= WAIT_SYNC;
            end

            if (idle_hit) begin
                idle_o <= 1'b1;
                state  <= WAIT_SYNC;
                armed  <= 1'b0;
                idx    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sent_rx_pulse_decoder.sv
// Scoreboard bench for sent_rx_pulse_decoder: directed SENT waveforms, expected strobes queued in order.
// Expectations for the frame-length check follow SENT_RX_FRAME_CHECK_EN.
module tb_sent_rx_pulse_decoder;

`ifdef SENT_RX_FRAME_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic       clk_tx = 1'b0;
    logic       reset_n_tx;
    logic       ticks_i;
    logic       sent_rx_i;
    logic [3:0] nibble_o, nibble_idx_o;
    logic       nibble_valid_o, sync_o, pause_o, frame_done_o, idle_o, err_o;
    logic [1:0] err_code_o;

    sent_rx_pulse_decoder #(
        .NIBBLES(6), .LOW_MIN(4), .IDLE_TICKS(64), .FRAME_TICKS(280)
    ) dut (
        .clk_tx         (clk_tx),
        .reset_n_tx     (reset_n_tx),
        .ticks_i        (ticks_i),
        .sent_rx_i      (sent_rx_i),
        .nibble_o       (nibble_o),
        .nibble_idx_o   (nibble_idx_o),
        .nibble_valid_o (nibble_valid_o),
        .sync_o         (sync_o),
        .pause_o        (pause_o),
        .frame_done_o   (frame_done_o),
        .idle_o         (idle_o),
        .err_o          (err_o),
        .err_code_o     (err_code_o)
    );

    always #5 clk_tx = ~clk_tx;

    // Tick strobe: 8 clk period, inputs driven on the falling clock edge.
    initial begin
        ticks_i = 1'b0;
        forever begin
            repeat (4) @(negedge clk_tx);
            ticks_i = 1'b1;
            repeat (4) @(negedge clk_tx);
            ticks_i = 1'b0;
        end
    end

    typedef struct packed {
        logic       sync;
        logic       pause;
        logic       nv;
        logic       fd;
        logic       err;
        logic [1:0] code;
        logic [3:0] nib;
        logic [3:0] idx;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  n_ev   = 0;
    int  frame_sum = 0;
    int  nibs_a[8] = '{0, 3, 15, 0, 7, 9, 1, 5};
    int  nibs_b[8] = '{2, 14, 1, 6, 8, 10, 4, 11};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic ev_t mk(bit s, bit p, bit v, bit f, bit e, logic [1:0] c,
                               logic [3:0] n, logic [3:0] i);
        ev_t r;
        r = '{sync: s, pause: p, nv: v, fd: f, err: e, code: c, nib: n, idx: i};
        return r;
    endfunction

    // Monitor: pops one expectation per cycle that carries any strobe.
    always @(negedge clk_tx) begin
        ev_t obs, e;
        if (reset_n_tx && (sync_o || pause_o || nibble_valid_o || frame_done_o || err_o)) begin
            obs = mk(sync_o, pause_o, nibble_valid_o, frame_done_o, err_o,
                     err_o ? err_code_o : 2'b00,
                     nibble_valid_o ? nibble_o : 4'h0,
                     nibble_valid_o ? nibble_idx_o : 4'h0);
            n_ev++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event%0d: got 0x%0h expected none", n_ev, obs);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("event%0d", n_ev), 32'(obs), 32'(e));
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge ticks_i);
        repeat (2) @(negedge clk_tx);
    endtask

    task automatic pulse(input int total, input int low);
        sent_rx_i = 1'b0;
        wait_ticks(low);
        sent_rx_i = 1'b1;
        wait_ticks(total - low);
    endtask

    task automatic sync_pulse();
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0));
        pulse(56, 5);
        frame_sum = 56;
    endtask

    task automatic frame_body(input bit sel);
        int v;
        for (int i = 0; i < 8; i++) begin
            v = sel ? nibs_b[i] : nibs_a[i];
            exp_q.push_back(mk(0, 0, 1, i == 7, 0, 2'b00, 4'(v), 4'(i)));
            pulse(12 + v, 5);
            frame_sum += 12 + v;
        end
    endtask

    task automatic send_pause(input int len);
        bit bad;
        frame_sum += len;
        bad = FCHK && frame_sum != 280;
        exp_q.push_back(mk(0, 1, 0, 0, bad, bad ? 2'b11 : 2'b00, 4'h0, 4'h0));
        pulse(len, len / 2 + 20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n_tx = 1'b0;
        sent_rx_i  = 1'b1;
        repeat (5) @(negedge clk_tx);
        check("rst_idle", 32'(idle_o), 32'd1);
        check("rst_strobes", 32'({sync_o, pause_o, nibble_valid_o, frame_done_o, err_o}), 32'd0);
        check("rst_nibble", 32'(nibble_o), 32'd0);
        check("rst_idx", 32'(nibble_idx_o), 32'd0);
        check("rst_err_code", 32'(err_code_o), 32'd0);
        reset_n_tx = 1'b1;
        wait_ticks(1);

        // Valid frame: first fall only arms, then sync, 8 nibbles, pause 143.
        sync_pulse();
        frame_body(1'b0);
        send_pause(143);

        // Out-of-range nibble, resync, then a low-time violation.
        sync_pulse();
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 4'h0, 4'h0));
        pulse(30, 5);
        sync_pulse();
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b10, 4'h0, 4'h0));
        pulse(12, 2);

        // Idle mid-frame: sync accepted, then line held high past the idle limit.
        sync_pulse();
        sent_rx_i = 1'b0;
        wait_ticks(5);
        check("idle_before", 32'(idle_o), 32'd0);
        sent_rx_i = 1'b1;
        wait_ticks(70);
        check("idle_set", 32'(idle_o), 32'd1);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0));
        sent_rx_i = 1'b0;
        wait_ticks(1);
        check("idle_cleared", 32'(idle_o), 32'd0);
        wait_ticks(4);
        sent_rx_i = 1'b1;
        wait_ticks(51);
        frame_sum = 56;

        // Back-to-back frames: CRC followed directly by sync.
        frame_body(1'b0);
        sync_pulse();
        frame_body(1'b1);
        send_pause(280 - frame_sum);

        // Frame length one tick long, then exact.
        sync_pulse();
        frame_body(1'b0);
        send_pause(281 - frame_sum);
        sync_pulse();
        frame_body(1'b0);
        send_pause(280 - frame_sum);

        // Closing fall classifies the last pause.
        sent_rx_i = 1'b0;
        wait_ticks(5);
        sent_rx_i = 1'b1;
        wait_ticks(3);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk_tx);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("idle_end", 32'(idle_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sent_rx_pulse_decoder.md
Name: sent_rx_pulse_decoder

Overview:
- Receive-side counterpart of the SENT transmit pulse generator.
- Samples the SENT line, counts tick strobes between consecutive falling edges, and classifies each interval as sync, nibble, pause or error.
- Tracks frame position and emits decoded nibbles with index, plus sync/pause/frame/idle/error indications, to the downstream frame assembler and CRC checker.

Parameters:
- NIBBLES, 6, data nibbles per frame (status and CRC not counted).
- LOW_MIN, 4, minimum low ticks accepted after each falling edge.
- IDLE_TICKS, 64, continuous-high ticks that declare idle.
- FRAME_TICKS, 280, required total frame length in ticks (optional feature only).

Ports:
- clk_tx  in  1  system clock.
- reset_n_tx  in  1  reset.
- ticks_i  in  1  tick strobe; each rising edge is one tick; period >= 4 clk_tx.
- sent_rx_i  in  1  SENT line, asynchronous.
- nibble_o  out  4  decoded nibble value.
- nibble_idx_o  out  4  nibble position: 0 = status, 1..NIBBLES = data, NIBBLES+1 = CRC.
- nibble_valid_o  out  1  one-cycle strobe qualifying nibble_o and nibble_idx_o.
- sync_o  out  1  one-cycle strobe: sync interval accepted.
- pause_o  out  1  one-cycle strobe: pause interval accepted.
- frame_done_o  out  1  one-cycle strobe, same cycle as the CRC nibble_valid_o.
- idle_o  out  1  level: line idle.
- err_o  out  1  one-cycle strobe: error.
- err_code_o  out  2  01 nibble out of range; 10 low time short; 11 frame length mismatch; held until the next error.

Behaviour:
- Reset is asynchronous, active-low on reset_n_tx; clock is clk_tx.
- Reset values: all strobes 0, nibble_o 0, nibble_idx_o 0, err_code_o 0, idle_o 1. State WAIT_SYNC, armed 0, counters 0.
- Line conditioning: sent_rx_i passes through a 2-flop synchronizer, then edge detect.
- Tick detect: a rising edge of ticks_i, registered against its previous value, is one tick.
- Interval counter: 10 bits, saturates at 1023, increments per tick.
- At each falling edge:
  - If armed, interval = counter value; classify it.
  - Then clear the counter and set armed=1.
  - The first fall after reset or after idle only arms; nothing is classified.
- Low-time counter counts ticks while the line is low. At the rising edge, if low count < LOW_MIN: err 10, state WAIT_SYNC.
- All outputs are registered. Strobes assert on the cycle after the falling edge is detected (about 3 clk after the line edge).
- State machine:
  - WAIT_SYNC:
    - 56 → sync_o, idx=0, go DATA.
    - Any other value is discarded silently.
  - DATA:
    - 12..27 → nibble_o = interval-12, nibble_valid_o, nibble_idx_o = idx, then idx++.
    - When idx = NIBBLES+1, also frame_done_o, go PAUSE.
    - 56 → err 01 (short frame) and sync_o in the same cycle, idx=0, stay in DATA.
    - Any other value → err 01, go WAIT_SYNC.
  - PAUSE:
    - 56 → sync_o, go DATA (frame without pause).
    - 12..768 → pause_o, go WAIT_SYNC.
    - Otherwise (including saturation) → err 01, go WAIT_SYNC.
- Idle:
  - In any state, line high for IDLE_TICKS consecutive ticks → idle_o=1, state WAIT_SYNC, armed=0, idx=0.
  - idle_o clears on the next falling edge.
- Simultaneous events: an error always sets err_code_o. Sync after error is a legal combination.
- Reset mid-frame: everything returns to reset values immediately; no strobes are generated.

Optional Feature:
- Macro: SENT_RX_FRAME_CHECK_EN.
- With the macro defined:
  - A 10-bit accumulator sums every classified interval from the sync onward.
  - On pause acceptance, if the sum != FRAME_TICKS, assert err_o with code 11; pause_o still pulses.
  - The accumulator clears on sync_o and on idle.
- Without the macro: no accumulator, code 11 is never produced, and pause is accepted on range alone.

Decomposition:
- Package sent_pkg:
  - constants SYNC_TICKS=56, NIB_OFFSET=12, NIB_MAX_TICKS=27, PAUSE_MIN=12, PAUSE_MAX=768.
  - state enum {WAIT_SYNC, DATA, PAUSE}.
  - error code constants.
  - Shared with the transmitter.
- Sub-module sent_rx_sync_edge: 2-flop synchronizer plus registered rise/fall detect. Instantiated once for sent_rx_i; the tick edge detect reuses it.

Test Plan:
- Valid frame: sync 56, status 0 (12 ticks), data 3,15,0,7,9,1, CRC 5 (17 ticks), pause 143 → sync_o, eight nibble_valid_o with idx 0..7 and values 0,3,15,0,7,9,1,5; frame_done_o with idx 7; pause_o; err_o never.
- Out-of-range: after sync, interval 30 → err_o with code 01, no nibble_valid_o, next 56 gives sync_o.
- Low-time violation: interval 12 with only 2 low ticks → err code 10, return to WAIT_SYNC.
- Idle: line held high 64 ticks mid-frame → idle_o=1, no strobes. A following falling edge plus an interval of 56 → idle_o clears, then sync_o on the second fall.
- Back-to-back frames with no pause (CRC then 56) → frame_done_o, then sync_o, then next frame decodes normally.
- SENT_RX_FRAME_CHECK_EN defined: pause sized for a 281-tick frame → pause_o and err code 11. Exact 280-tick frame → no error.
